// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: drives an 8-bit HD44780-style character LCD bus.
// After reset it waits for the panel to power up and then sends a fixed
// initialisation sequence. After that it accepts one command/character at a
// time over a valid/ready handshake. Each write gets an RS/DATA setup phase,
// an EN pulse of fixed width and an execution wait. Clear and home commands
// get the long wait.
module lcd_bus_sequencer #(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 4,
    parameter int EN_HIGH_CYC = 16,
    parameter int EXEC_CYC    = 2500,
    parameter int CLEAR_CYC   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON
);

    typedef enum logic [2:0] {
        PWRUP, INIT_SETUP, INIT_EN, INIT_WAIT, IDLE, SETUP, EN_HI, WAIT
    } state_t;

    // Each timed state loads count-1 and leaves on the cycle the counter hits 0.
    // The power-up load is the full count because the reset cycle itself is
    // not part of the post-reset wait.
    localparam logic [19:0] CNT_POWERUP = 20'(POWERUP_CYC);
    localparam logic [19:0] CNT_SETUP   = 20'(SETUP_CYC - 1);
    localparam logic [19:0] CNT_EN      = 20'(EN_HIGH_CYC - 1);
    localparam logic [19:0] CNT_EXEC    = 20'(EXEC_CYC - 1);
    localparam logic [19:0] CNT_CLEAR   = 20'(CLEAR_CYC - 1);
    localparam logic [2:0]  LAST_INIT   = 3'd5;

    state_t      state_reg, state_next;
    logic [19:0] cnt_reg, cnt_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  data_reg, data_next;
    logic        rs_reg, rs_next;
    logic        en_reg, en_next;
    logic        on_reg, on_next;
    logic        done_reg, done_next;
    logic        cnt_zero;
    logic        accept;

    // Initialisation command ROM: 8-bit 2-line mode x3, display on, clear, entry mode.
    function automatic logic [7:0] init_rom(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h01;
            3'd5:             init_rom = 8'h06;
            default:          init_rom = 8'h00;
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
    function automatic logic [19:0] wait_load(input logic rs, input logic [7:0] d);
        if (!rs && (d[7:1] == 7'h00 || d[7:1] == 7'h01))
            wait_load = CNT_CLEAR;
        else
            wait_load = CNT_EXEC;
    endfunction

    assign cnt_zero  = (cnt_reg == 20'd0);
    assign req_ready = (state_reg == IDLE) && done_reg;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_reg != IDLE);
    assign init_done = done_reg;
    assign LCD_DATA  = data_reg;
    assign LCD_RS    = rs_reg;
    assign LCD_RW    = 1'b0;
    assign LCD_EN    = en_reg;
    assign LCD_ON    = on_reg;
    assign LCD_BLON  = on_reg;

    // Next-state and next-output logic; init and normal writes share timing.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg - 20'd1;
        idx_next   = idx_reg;
        data_next  = data_reg;
        rs_next    = rs_reg;
        en_next    = en_reg;
        on_next    = 1'b1;
        done_next  = done_reg;
        case (state_reg)
            PWRUP: begin
                if (cnt_zero) begin
                    state_next = INIT_SETUP;
                    cnt_next   = CNT_SETUP;
                    data_next  = init_rom(3'd0);
                    rs_next    = 1'b0;
                end
            end
            INIT_SETUP, SETUP: begin
                if (cnt_zero) begin
                    state_next = (state_reg == SETUP) ? EN_HI : INIT_EN;
                    en_next    = 1'b1;
                    cnt_next   = CNT_EN;
                end
            end
            INIT_EN, EN_HI: begin
                if (cnt_zero) begin
                    state_next = (state_reg == EN_HI) ? WAIT : INIT_WAIT;
                    en_next    = 1'b0;
                    cnt_next   = wait_load(rs_reg, data_reg);
                end
            end
            INIT_WAIT: begin
                if (cnt_zero) begin
                    if (idx_reg == LAST_INIT) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = INIT_SETUP;
                        idx_next   = idx_reg + 3'd1;
                        data_next  = init_rom(idx_reg + 3'd1);
                        cnt_next   = CNT_SETUP;
                    end
                end
            end
            IDLE: begin
                cnt_next = cnt_reg;
                if (accept) begin
                    state_next = SETUP;
                    rs_next    = req_rs;
                    data_next  = req_data;
                    cnt_next   = CNT_SETUP;
                end
            end
            WAIT: begin
                if (cnt_zero)
                    state_next = IDLE;
            end
            default: begin
                state_next = PWRUP;
                cnt_next   = CNT_POWERUP;
            end
        endcase
    end

    // State and output registers; reset drops EN and power at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= PWRUP;
            cnt_reg   <= CNT_POWERUP;
            idx_reg   <= 3'd0;
            data_reg  <= 8'h00;
            rs_reg    <= 1'b0;
            en_reg    <= 1'b0;
            on_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            rs_reg    <= rs_next;
            en_reg    <= en_next;
            on_reg    <= on_next;
            done_reg  <= done_next;
        end
    end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: stimulus pushes the expected {rs,data} of each
// write onto a queue; a monitor pops one entry per EN pulse and checks it,
// along with the pulse width. Timing checks are made by the driver.
module tb_lcd_bus_sequencer;

    localparam int P = 10;
    localparam int S = 2;
    localparam int H = 3;
    localparam int E = 5;
    localparam int C = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       init_done;
    logic       busy;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int cyc        = 0;
    logic [8:0] exp_q[$];

    lcd_bus_sequencer #(
        .POWERUP_CYC(P), .SETUP_CYC(S), .EN_HIGH_CYC(H),
        .EXEC_CYC(E), .CLEAR_CYC(C)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data),
        .init_done(init_done), .busy(busy),
        .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    // Called 1 time unit after a rising edge; applies one reset edge.
    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_state",
            {LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, init_done, req_ready, busy},
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        push_init();
        rst = 1'b0;
    endtask

    // Counts edges after reset release until init_done; expects P+1+5*10+25.
    task automatic wait_init();
        int   n;
        logic early;
        n = 0;
        early = 1'b0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("power_on", {LCD_ON, LCD_BLON}, 2'b11);
            if (req_ready && !init_done) early = 1'b1;
            if (init_done) break;
        end
        chk("init_done_cycle", n, P + 1 + 5 * (S + H + E) + (S + H + C));
        chk("ready_before_init", early, 1'b0);
        chk("idle_after_init", {req_ready, busy}, 2'b10);
    endtask

    // One handshake write; reports cycles to req_ready return and first EN cycle.
    task automatic do_write(input logic rs, input logic [7:0] d, output int lat, output int en_first);
        int n;
        lat = -1;
        en_first = -1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        exp_q.push_back({rs, d});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rs    = ~rs;
        req_data  = ~d;
        chk("setup_bus", {LCD_RS, LCD_DATA, LCD_EN}, {rs, d, 1'b0});
        n = 1;
        while (n < 100) begin
            if (LCD_EN && en_first < 0) en_first = n;
            if (req_ready) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Scoreboard monitor: one expected entry per EN pulse, width must be H.
    initial begin
        logic       in_pulse;
        int         width;
        logic [8:0] e;
        in_pulse = 1'b0;
        width = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pulse = 1'b0;
            end else if (!in_pulse && LCD_EN) begin
                in_pulse = 1'b1;
                width = 1;
                pulses++;
                $display("pulse %0d: rs=%0d data=0x%02h rw=%0d cycle %0d", pulses, LCD_RS, LCD_DATA, LCD_RW, cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {LCD_RS, LCD_DATA}, 9'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_bus", {LCD_RW, LCD_RS, LCD_DATA}, {1'b0, e});
                end
            end else if (in_pulse && LCD_EN) begin
                width++;
            end else if (in_pulse && !LCD_EN) begin
                in_pulse = 1'b0;
                chk("en_width", width, H);
            end
        end
    end

    // Stimulus.
    initial begin
        int    lat, enf, n, acc, prev;
        string msg;
        msg = "Result: 0x3A    ";
        repeat (2) @(posedge clk);
        #1;

        // 1: reset state, power-up and init sequence
        apply_reset();
        wait_init();

        // 2: single data write
        do_write(1'b1, 8'h52, lat, enf);
        chk("data_latency", lat, S + H + E + 1);
        chk("data_en_start", enf, S + 1);

        // 3: home/clear get the long wait only with rs=0
        do_write(1'b0, 8'h02, lat, enf);
        chk("home_latency", lat, S + H + C + 1);
        do_write(1'b1, 8'h02, lat, enf);
        chk("data02_latency", lat, S + H + E + 1);
        do_write(1'b0, 8'h03, lat, enf);
        chk("home03_latency", lat, S + H + C + 1);
        do_write(1'b0, 8'h04, lat, enf);
        chk("cmd04_latency", lat, S + H + E + 1);

        // 4: streaming with req_valid held high
        req_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            while (!req_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (!req_ready) chk("stream_ready_timeout", 0, 1);
            req_rs   = 1'b1;
            req_data = msg[i];
            exp_q.push_back({1'b1, msg[i]});
            @(posedge clk); #1;
            acc = cyc;
            if (i > 0) chk("stream_spacing", acc - prev, S + H + E + 1);
            prev = acc;
        end
        req_valid = 1'b0;

        // 5: request held through reset and init
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h51;
        apply_reset();
        exp_q.push_back({1'b1, 8'h51});
        wait_init();
        @(posedge clk); #1;
        chk("early_accept", {req_ready, busy, LCD_RS, LCD_DATA}, {1'b0, 1'b1, 1'b1, 8'h51});
        req_valid = 1'b0;
        n = 1;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("early_latency", n, S + H + E + 1);

        // 6: reset in the second EN_HI cycle of a data write
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        exp_q.push_back({1'b1, 8'h5A});
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!LCD_EN && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_en_seen", LCD_EN, 1'b1);
        @(posedge clk); #1;
        chk("abort_en_second", LCD_EN, 1'b1);
        apply_reset();
        wait_init();

        repeat (40) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("pulse_count", pulses, 41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_bus_sequencer.md
# lcd_bus_sequencer

Sequences the 8-bit HD44780-style character LCD bus for the board's display path.
- After reset, runs the power-up wait and the fixed initialisation command sequence.
- Then accepts one command or character write at a time from upstream display logic over a valid/ready handshake.
- Generates the RS/DATA setup, the EN pulse and the post-write execution wait for each accepted write.
- Sits between the string/format logic (message buffers, hex formatters) and the LCD pins, and is the only block that drives them.

## Interface
Parameters (all in clk cycles; each must satisfy 1 <= value < 2^20):
- POWERUP_CYC, 750000, wait after reset before the first init command (15 ms at 50 MHz)
- SETUP_CYC, 4, RS/DATA stable before EN rises
- EN_HIGH_CYC, 16, EN high width
- EXEC_CYC, 2500, wait after EN falls for normal commands and data (50 us)
- CLEAR_CYC, 82000, wait after EN falls for clear/home commands (1.64 ms)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  upstream has a write pending
- req_ready  out  1  block can accept a write this cycle
- req_rs  in  1  0 = command, 1 = character data
- req_data  in  8  command or character byte
- init_done  out  1  initialisation sequence complete
- busy  out  1  high in every state except IDLE
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  register select
- LCD_RW  out  1  read/write; tied to 0 (write only)
- LCD_EN  out  1  enable strobe
- LCD_ON  out  1  LCD power enable
- LCD_BLON  out  1  backlight enable

## Operation
- **States:** PWRUP, INIT_SETUP, INIT_EN, INIT_WAIT, IDLE, SETUP, EN_HI, WAIT. A single 20-bit down-counter serves all timed states.
- **Reset values:** state PWRUP; LCD_DATA=0x00; LCD_RS=0; LCD_RW=0; LCD_EN=0; LCD_ON=0; LCD_BLON=0; init_done=0; req_ready=0; busy=1; init index=0.
- **PWRUP:** LCD_ON and LCD_BLON go to 1 on the first cycle after rst deasserts and stay 1 until the next reset. The block holds for POWERUP_CYC cycles, then moves to INIT_SETUP.
- **Init ROM:** 6 entries, index 0..5: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. All are sent with RS=0.
- **Init write sequence:** each entry goes INIT_SETUP → INIT_EN → INIT_WAIT, using the same timing as a normal write.
  - After index 5 finishes INIT_WAIT: init_done=1 and the state goes to IDLE.
  - init_done stays 1 until reset.
- **IDLE:** req_ready=1 only here, and only once init_done=1.
  - A write is accepted when req_valid && req_ready on a rising edge.
  - {req_rs, req_data} are captured at acceptance. Later changes on req_* have no effect on the write in flight.
- **SETUP:** LCD_RS and LCD_DATA are driven from the captured values, LCD_EN=0, for SETUP_CYC cycles.
- **EN_HI:** LCD_EN=1 for EN_HIGH_CYC cycles. RS and DATA are unchanged.
- **WAIT:** LCD_EN=0. RS and DATA hold their last values.
  - Wait length is CLEAR_CYC if RS=0 and data[7:1] is 0x00 (clear, 0x01) or data[7:1] is 0x01 (home, 0x02/0x03).
  - Otherwise the wait length is EXEC_CYC.
  - The same selection rule applies to init entries.
- **Reset mid-operation:** rst in any state returns all outputs to their reset values on the next edge.
  - LCD_EN falls immediately, even if rst arrives mid-pulse.
  - Any in-flight or captured write is discarded.
  - The full power-up wait and init sequence rerun after reset.
- **No queue:** requests presented while req_ready=0 are neither lost nor consumed. Upstream must hold req_valid.

## Timing
- Acceptance edge = cycle 0.
- Cycles 1..S: SETUP, EN=0, with RS and DATA valid from cycle 1.
- Cycles S+1..S+H: EN=1.
- Cycles S+H+1..S+H+W: WAIT.
- Cycle S+H+W+1: IDLE with req_ready=1.
- Here S=SETUP_CYC, H=EN_HIGH_CYC, W=EXEC_CYC or CLEAR_CYC.
- Maximum write throughput is one write per S+H+W+1 cycles. Back-to-back writes are accepted in the first IDLE cycle.
- Init: the first INIT_SETUP cycle is POWERUP_CYC+1 cycles after rst deasserts. init_done rises on the same edge the state enters IDLE.
- The EN pulse is always exactly H cycles. It is never truncated, except by reset.

## Test plan
All scenarios use POWERUP_CYC=10, SETUP_CYC=2, EN_HIGH_CYC=3, EXEC_CYC=5, CLEAR_CYC=20.
1. **Init sequence:** release rst.
   - LCD_ON and LCD_BLON go to 1 the next cycle.
   - Six EN pulses, 3 cycles each, RS=0, DATA 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
   - 5-cycle gap after each pulse, except 20 cycles after 0x01.
   - init_done=1 and req_ready=1 at the end.
2. **Single data write:** write rs=1, data=0x52 ('R').
   - RS=1 and DATA=0x52 from cycle 1.
   - EN high in cycles 3..5.
   - req_ready back to 1 at cycle 11.
   - LCD_RW stays 0 throughout.
3. **Home command:** write rs=0, data=0x02.
   - WAIT lasts 20 cycles; req_ready returns at cycle 26.
   - rs=1, data=0x02 gives a 5-cycle wait instead.
4. **Streaming:** hold req_valid high and feed 16 characters "Result: 0x3A    ".
   - Exactly 16 EN pulses, in order, no duplicates.
   - Accepts spaced exactly 11 cycles apart.
5. **Request during init:** assert req_valid from rst release.
   - req_ready stays 0 until init_done.
   - The request is accepted on the first IDLE cycle and appears as the 7th EN pulse.
6. **Reset mid-pulse:** assert rst in the 2nd EN_HI cycle of a data write.
   - LCD_EN=0, LCD_ON=0 and init_done=0 on the next edge.
   - After release, the full init sequence repeats and the aborted character is never re-sent.
